// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words into a downstream synchronous FIFO, honouring fifo_full.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    // Rotating priority scan starting just above the last served requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(last_grant) + 1 + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (state == GRANT) begin
            req_ready  = fifo_full ? '0 : (NUM_REQ'(1) << gidx);
            fifo_wr_en = req_valid[gidx] && !fifo_full;
            fifo_din   = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            gidx       <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state    <= GRANT;
                        grant    <= NUM_REQ'(1) << sel_idx;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        gidx     <= sel_idx;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // A requester that withdraws gives up the rest of its burst.
                    if (!req_valid[gidx] ||
                        (fifo_wr_en && beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state      <= IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        beat_cnt   <= '0;
                        last_grant <= gidx;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
